board_scan_sequencer: RTL and testbench
=======================================

BOARD_SCAN_SEQUENCER -- requirements
Module: board_scan_sequencer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- COLS, 9: board columns.
- ROWS, 9: board rows.
- CELL, 40: cell pitch in pixels; equals the draw-stage square width.
- ORIGIN_X, 140: screen x of cell (0,0).
- ORIGIN_Y, 60: screen y of cell (0,0).
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, in, 1: sole clock.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: begin one full board scan.
- skip_empty, in, 1: sampled with start; 1 = empty cells are not drawn.
- mem_addr, out, 7: board-state RAM read address, row*COLS+col.
- mem_data, in, 2: RAM read data, valid one cycle after mem_addr; 00 empty, 01 black, 10 white, 11 marker.
- initial_xPosition, out, 10: top-left x of the square being drawn.
- initial_yPosition, out, 9: top-left y of the square being drawn.
- colour, out, 3: RGB colour of the square being drawn.
- draw_enable, out, 1: enables the draw stage counters.
- plot_enable, out, 1: enables VGA pixel writes.
- finished, in, 1: one-cycle pulse from the draw stage when the square is complete.
- busy, out, 1: scan in progress.
- done, out, 1: one-cycle pulse when a scan completes.

Function
REQ-003 All outputs shall be registered.
REQ-004 The FSM shall have the states IDLE, READ, LATCH, DRAW, NEXT and DONE.
REQ-005 IDLE: if start=1, capture skip_empty, clear row/col, set mem_addr=0 and go to READ; otherwise remain.
REQ-006 READ shall last exactly one cycle and then go to LATCH; mem_data is valid in LATCH.
REQ-007 LATCH:
- Map colour: 00→3'b110, 01→3'b000, 10→3'b111, 11→3'b100.
- If mem_data=00 and skip_empty=1, go to NEXT.
- Otherwise go to DRAW.
REQ-008 In DRAW, draw_enable and plot_enable shall be 1, and initial_xPosition/initial_yPosition/colour shall be held stable.
REQ-009 DRAW shall remain until finished=1; draw_enable and plot_enable shall be 0 in the cycle after finished is sampled.
REQ-010 The draw position shall be ORIGIN_X+col*CELL and ORIGIN_Y+row*CELL, computed by incremental add of CELL.
- x shall reset to ORIGIN_X on row advance.
- No multiplier is permitted.
REQ-011 NEXT:
- If col<COLS-1, increment col.
- Otherwise set col=0 and increment row.
- mem_addr shall increment by 1; go to READ.
- If row=ROWS-1 and col=COLS-1, go to DONE instead.
REQ-012 DONE shall pulse done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-013 busy shall be 1 in every state except IDLE.
REQ-014 Latency: with start sampled at edge N, mem_addr=0 after N, and draw_enable=1 after N+2 for a non-skipped cell.
REQ-015 Per-cell overhead outside DRAW shall be exactly 3 cycles (NEXT, READ, LATCH).
REQ-016 start shall be ignored while busy=1.
REQ-017 A finished pulse outside DRAW shall be ignored.
REQ-018 skip_empty changes during a scan shall have no effect.
REQ-019 Counter widths:
- row and col: 4 bits.
- mem_addr shall never exceed ROWS*COLS-1 (80).
- x shall never exceed ORIGIN_X+(COLS-1)*CELL (460); y shall never exceed 380.

Reset
REQ-020 When reset=0, regardless of clock, the block shall enter IDLE and all outputs shall be 0, including mem_addr, positions and colour.
REQ-021 Reset asserted mid-DRAW shall drop draw_enable and plot_enable immediately; no done pulse shall be produced.
REQ-022 After reset release, the block shall wait for a fresh start.

Verification
REQ-023 Single stone: board all empty except addr 10=01, skip_empty=1, draw model finishing after 1600 cycles -> exactly one DRAW at (180,100) with colour 000; done pulses once.
REQ-024 Full board, skip_empty=0, alternating 01/10 -> 81 draws, last at (460,380) colour 111 or 000 per data; scan length 81*(1600+1+3)+small constant cycles.
REQ-025 All empty, skip_empty=1 -> draw_enable never rises; done after 81*3+2 cycles.
REQ-026 Start pulsed during busy, plus spurious finished in NEXT -> scan unaffected; single done.
REQ-027 Reset asserted at cycle 500 of the third cell's DRAW -> outputs 0 asynchronously; new start rescans from addr 0.
REQ-028 Wrap check: cell (row 0, col 8) followed by (row 1, col 0) -> x goes 460→140 and y goes 60→100; mem_addr goes 8→9.

Source files
------------

// File: rtl/board_scan_sequencer.sv
// Board scan sequencer: walks every cell of the board-state RAM in row-major
// order, maps each stone to a colour and hands one square at a time to the
// draw stage. The screen position advances by repeated addition of the cell
// pitch, so no multiplier is needed.
//
// Handshake: draw_enable/plot_enable rise together when a square is offered.
// They stay high, with position and colour held constant, until a
// one-cycle finished pulse is sampled. finished is ignored in every other
// state.
module board_scan_sequencer #(
    parameter int COLS     = 9,
    parameter int ROWS     = 9,
    parameter int CELL     = 40,
    parameter int ORIGIN_X = 140,
    parameter int ORIGIN_Y = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       skip_empty,
    output logic [6:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [9:0] initial_xPosition,
    output logic [8:0] initial_yPosition,
    output logic [2:0] colour,
    output logic       draw_enable,
    output logic       plot_enable,
    input  logic       finished,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_DRAW  = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [9:0] X0       = 10'(ORIGIN_X);
    localparam logic [9:0] DX       = 10'(CELL);
    localparam logic [8:0] Y0       = 9'(ORIGIN_Y);
    localparam logic [8:0] DY       = 9'(CELL);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic       r_skip;
    logic [6:0] r_addr;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic [2:0] r_colour;
    logic       r_draw;
    logic       r_busy;
    logic       r_done;
    logic       w_last;

    assign w_last = (r_row == LAST_ROW) && (r_col == LAST_COL);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE, finished only in DRAW.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = (mem_data == 2'b00 && r_skip) ? S_NEXT : S_DRAW;
            S_DRAW:  if (finished) w_next = S_NEXT;
            S_NEXT:  w_next = w_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered outputs and scan counters; strobes are decoded from the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_row    <= 4'd0;
            r_col    <= 4'd0;
            r_skip   <= 1'b0;
            r_addr   <= 7'd0;
            r_x      <= 10'd0;
            r_y      <= 9'd0;
            r_colour <= 3'd0;
            r_draw   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_draw <= (w_next == S_DRAW);
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_skip <= skip_empty;
                        r_row  <= 4'd0;
                        r_col  <= 4'd0;
                        r_addr <= 7'd0;
                        r_x    <= X0;
                        r_y    <= Y0;
                    end
                end
                S_LATCH: begin
                    case (mem_data)
                        2'b00:   r_colour <= 3'b110;
                        2'b01:   r_colour <= 3'b000;
                        2'b10:   r_colour <= 3'b111;
                        default: r_colour <= 3'b100;
                    endcase
                end
                S_NEXT: begin
                    if (!w_last) begin
                        r_addr <= r_addr + 7'd1;
                        if (r_col < LAST_COL) begin
                            r_col <= r_col + 4'd1;
                            r_x   <= r_x + DX;
                        end else begin
                            r_col <= 4'd0;
                            r_row <= r_row + 4'd1;
                            r_x   <= X0;
                            r_y   <= r_y + DY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr          = r_addr;
    assign initial_xPosition = r_x;
    assign initial_yPosition = r_y;
    assign colour            = r_colour;
    assign draw_enable       = r_draw;
    assign plot_enable       = r_draw;
    assign busy              = r_busy;
    assign done              = r_done;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_board_scan_sequencer.sv
// Bench for board_scan_sequencer: RAM model, draw-stage model, a reference
// model of the expected draw list, and a monitor that checks draws, address
// stepping and done pulses against it.
module tb_board_scan_sequencer;

    localparam int COLS  = 9;
    localparam int ROWS  = 9;
    localparam int CELL  = 40;
    localparam int OX    = 140;
    localparam int OY    = 60;
    localparam int NCELL = COLS * ROWS;

    // ---------------- clock / reset / signals ----------------
    logic       clock = 1'b0;
    logic       reset;
    logic       start, start_main, start_noise;
    logic       skip_empty, skip_main, skip_noise;
    logic       finished, finished_m, finished_noise;
    logic [6:0] mem_addr;
    logic [1:0] mem_data;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic [2:0] colour;
    logic       draw_enable, plot_enable, busy, done;
    logic [2:0] dbg_state;

    always #5 clock = ~clock;

    assign start      = start_main | start_noise;
    assign skip_empty = skip_main ^ skip_noise;
    assign finished   = finished_m | finished_noise;

    board_scan_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .skip_empty(skip_empty),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .initial_xPosition(x_pos), .initial_yPosition(y_pos), .colour(colour),
        .draw_enable(draw_enable), .plot_enable(plot_enable), .finished(finished),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------- environment models ----------------
    logic [1:0] board [0:NCELL-1];
    int         draw_len;
    int         dcnt;
    logic       noise_en;

    // Synchronous-read RAM: data follows the address by one cycle.
    always @(posedge clock) begin
        if (int'(mem_addr) < NCELL) mem_data <= board[int'(mem_addr)];
        else                        mem_data <= 2'b00;
    end

    // Draw stage: pulses finished once draw_enable has been seen for draw_len edges.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dcnt       <= 0;
            finished_m <= 1'b0;
        end else begin
            finished_m <= 1'b0;
            if (draw_enable && !finished_m) begin
                if (dcnt + 1 >= draw_len) begin
                    finished_m <= 1'b1;
                    dcnt       <= 0;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end else begin
                dcnt <= 0;
            end
        end
    end

    // Disturbances the sequencer must ignore: start while busy, skip_empty
    // flips mid-scan, finished while no square is offered.
    always @(negedge clock) begin
        start_noise    = noise_en && busy && ($urandom_range(0, 7) == 0);
        skip_noise     = noise_en && busy && ($urandom_range(0, 1) == 1);
        finished_noise = noise_en && !draw_enable && ($urandom_range(0, 5) == 0);
    end

    // ---------------- scoreboard ----------------
    logic [21:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input bit ok, input string name, input longint got, input longint want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [2:0] cmap(input logic [1:0] d);
        case (d)
            2'b00:   return 3'b110;
            2'b01:   return 3'b000;
            2'b10:   return 3'b111;
            default: return 3'b100;
        endcase
    endfunction

    // Reference: list of squares a scan must draw, in order.
    task automatic push_model(input logic skip, output int n_draw);
        int r;
        int c;
        n_draw = 0;
        for (int a = 0; a < NCELL; a++) begin
            r = a / COLS;
            c = a % COLS;
            if (!(skip && board[a] == 2'b00)) begin
                exp_q.push_back({10'(OX + c * CELL), 9'(OY + r * CELL), cmap(board[a])});
                n_draw++;
            end
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_de, prev_done, prev_busy, stable_ok;
    logic [6:0]  prev_addr;
    logic [21:0] cur;
    int          draws_seen = 0;
    int          done_seen  = 0;

    always @(negedge clock) begin
        if (!reset) begin
            prev_de   = 1'b0;
            prev_done = 1'b0;
            prev_busy = 1'b0;
            prev_addr = mem_addr;
        end else begin
            if (draw_enable && !prev_de) begin
                draws_seen++;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_draw", {x_pos, y_pos, colour}, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check({x_pos, y_pos, colour} == cur, "draw_xyc", {x_pos, y_pos, colour}, cur);
                    stable_ok = 1'b1;
                end
                check(plot_enable == 1'b1, "plot_with_draw", plot_enable, 1);
            end else if (draw_enable) begin
                if ({x_pos, y_pos, colour} != cur || !plot_enable) stable_ok = 1'b0;
            end
            if (!draw_enable && prev_de)
                check(stable_ok && !plot_enable, "draw_hold_stable", stable_ok, 1);
            if (mem_addr != prev_addr) begin
                if (!prev_busy) check(mem_addr == 7'd0, "addr_scan_start", mem_addr, 0);
                else            check(mem_addr == prev_addr + 7'd1, "addr_step", mem_addr, prev_addr + 1);
                check(int'(mem_addr) <= NCELL - 1, "addr_range", mem_addr, NCELL - 1);
            end
            if (done) begin
                done_seen++;
                check(!prev_done, "done_one_cycle", prev_done, 0);
                check(exp_q.size() == 0, "draws_outstanding_at_done", exp_q.size(), 0);
            end
            prev_de   = draw_enable;
            prev_done = done;
            prev_busy = busy;
            prev_addr = mem_addr;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_all_zero(input string tag);
        check(mem_addr == 0 && x_pos == 0 && y_pos == 0 && colour == 0, {tag, "_addr_pos_col"},
              {mem_addr, x_pos, y_pos, colour}, 0);
        check(draw_enable == 0 && plot_enable == 0, {tag, "_draw_plot"}, {draw_enable, plot_enable}, 0);
        check(busy == 0 && done == 0, {tag, "_busy_done"}, {busy, done}, 0);
    endtask

    task automatic run_scan(input logic skip, input int budget);
        int  cyc;
        int  n_draw;
        int  d0;
        int  dn0;
        bit  got;
        d0  = draws_seen;
        dn0 = done_seen;
        @(negedge clock);
        push_model(skip, n_draw);
        start_main = 1'b1;
        skip_main  = skip;
        cyc = 1;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clock);
            start_main = 1'b0;
            cyc++;
            if (done) got = 1'b1;
        end
        check(got, "scan_timeout", got, 1);
        if (got) check(cyc == 2 + NCELL * 3 + n_draw * (draw_len + 1), "scan_cycles",
                       cyc, 2 + NCELL * 3 + n_draw * (draw_len + 1));
        @(negedge clock);
        check(draws_seen - d0 == n_draw, "draw_count", draws_seen - d0, n_draw);
        check(done_seen - dn0 == 1, "done_count", done_seen - dn0, 1);
        check(busy == 1'b0, "idle_after_scan", busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int dn0;
        int n_dummy;
        bit got;
        reset      = 1'b0;
        start_main = 1'b0;
        skip_main  = 1'b0;
        noise_en   = 1'b0;
        draw_len   = 4;
        for (int a = 0; a < NCELL; a++) board[a] = 2'b00;

        #23;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_all_zero("post_reset_idle");

        // Single stone at address 10 -> square at (180,100), colour black.
        board[10] = 2'b01;
        draw_len  = 1600;
        run_scan(1'b1, 4000);

        // Empty board with skipping: no draws, pure 3-cycle-per-cell walk.
        board[10] = 2'b00;
        draw_len  = 4;
        run_scan(1'b1, 1000);

        // Full alternating board without skipping, including row wrap points.
        for (int a = 0; a < NCELL; a++) board[a] = (a % 2 == 1) ? 2'b10 : 2'b01;
        run_scan(1'b0, 2000);

        // Random boards with disturbances on start, skip_empty and finished.
        noise_en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int a = 0; a < NCELL; a++)
                board[a] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            draw_len = $urandom_range(1, 6);
            run_scan(1'($urandom_range(0, 1)), 3000);
        end
        noise_en = 1'b0;

        // Reset 500 cycles into the third square's draw.
        for (int a = 0; a < NCELL; a++) board[a] = 2'($urandom_range(1, 3));
        draw_len = 1600;
        d0  = draws_seen;
        dn0 = done_seen;
        @(negedge clock);
        push_model(1'b0, n_dummy);
        start_main = 1'b1;
        @(negedge clock);
        start_main = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clock);
            if (draws_seen - d0 >= 3) got = 1'b1;
        end
        check(got, "third_draw_timeout", draws_seen - d0, 3);
        repeat (500) @(negedge clock);
        check(draw_enable == 1'b1, "in_draw_before_reset", draw_enable, 1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        check(done_seen == dn0, "no_done_after_reset", done_seen - dn0, 0);
        check(busy == 1'b0 && mem_addr == 7'd0, "waits_for_start", {busy, mem_addr}, 0);

        // Fresh scan after reset rescans from address 0.
        draw_len = 2;
        run_scan(1'b0, 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
